// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the MEM-stage data responder.
// The decoder, the responder and the bench all import this package.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_HALF = 2'b01,
      SZ_BYTE = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   localparam logic [31:0] DEF_BASE_ADDR   = 32'h0002_0000;
   localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0003_FFF0;
   localparam int          DEF_DEPTH_WORDS = 4096;
   localparam int          DEF_CNT_W       = 16;

   typedef struct packed {
      logic        mreq;
      logic        write;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane decode: byte enables, alignment check, store-lane replication
// and load right-alignment for one 32-bit little-endian word.
module dmem_lane_ctrl
   import dmem_responder_pkg::*;
(
   input  logic [1:0]  byte_size,
   input  logic [1:0]  lane,
   input  logic [31:0] st_data,
   input  logic [31:0] rd_word,
   output logic [3:0]  byte_en,
   output logic        misaligned,
   output logic [31:0] st_lanes,
   output logic [31:0] ld_data
);

   logic [31:0] rd_shift;

   always_comb begin
      byte_en    = 4'b0000;
      misaligned = 1'b0;
      st_lanes   = '0;
      ld_data    = '0;
      rd_shift   = rd_word >> {lane, 3'b000};
      // Store data is replicated across lanes; byte_en picks the live ones.
      case (byte_size)
         SZ_WORD: begin
            misaligned = (lane != 2'b00);
            byte_en    = 4'b1111;
            st_lanes   = st_data;
            ld_data    = rd_word;
         end
         SZ_HALF: begin
            misaligned = lane[0];
            byte_en    = 4'b0011 << lane;
            st_lanes   = {2{st_data[15:0]}};
            ld_data    = {16'h0000, rd_shift[15:0]};
         end
         SZ_BYTE: begin
            byte_en    = 4'b0001 << lane;
            st_lanes   = {4{st_data[7:0]}};
            ld_data    = {24'h000000, rd_shift[7:0]};
         end
         default: misaligned = 1'b1;
      endcase
      if (misaligned) byte_en = 4'b0000;
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane stores and a zero-latency
// load path, plus tohost MMIO, sticky error flags and access counters.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter logic [31:0] TOHOST_ADDR = DEF_TOHOST_ADDR,
   parameter int          CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mreq,
   input  logic             write,
   input  logic [1:0]       byte_size,
   input  logic [31:0]      dad,
   input  logic [31:0]      ddt_in,
   output logic [31:0]      ddt_out,
   output logic [31:0]      tohost,
   output logic             tohost_valid,
   output logic             err_misaligned,
   output logic             err_range,
   output logic [CNT_W-1:0] load_cnt,
   output logic [CNT_W-1:0] store_cnt
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0]    off, rd_word, st_lanes, ld_al;
   logic [AW-1:0]  widx;
   logic [3:0]     be;
   logic           in_ram, th_word, mis, rng, ok, ld_ok, st_ok, ram_we;

   logic [31:0]      tohost_d, tohost_q;
   logic             tv_d, tv_q, emis_d, emis_q, erng_d, erng_q;
   logic [CNT_W-1:0] lcnt_d, lcnt_q, scnt_d, scnt_q;

   assign off     = dad - BASE_ADDR;
   assign in_ram  = (dad >= BASE_ADDR) && (off < RAM_BYTES);
   assign widx    = off[AW+1:2];
   assign rd_word = mem[widx];

   dmem_lane_ctrl u_lane (
      .byte_size  (byte_size),
      .lane       (dad[1:0]),
      .st_data    (ddt_in),
      .rd_word    (rd_word),
      .byte_en    (be),
      .misaligned (mis),
      .st_lanes   (st_lanes),
      .ld_data    (ld_al)
   );

   // Only a word access decodes as tohost; narrower ones there are range errors.
   assign th_word = (dad == TOHOST_ADDR) && (byte_size == SZ_WORD);
   assign rng     = !in_ram && !th_word;
   assign ok      = mreq && !mis && !rng;
   assign ld_ok   = ok && !write;
   assign st_ok   = ok && write;
   assign ram_we  = st_ok && !th_word;

   assign ddt_out = !ld_ok ? 32'h0 : (th_word ? tohost_q : ld_al);

   always_comb begin
      tohost_d = tohost_q;
      tv_d     = st_ok && th_word;
      emis_d   = emis_q | (mreq & mis);
      erng_d   = erng_q | (mreq & rng);
      lcnt_d   = lcnt_q + {{(CNT_W-1){1'b0}}, ld_ok};
      scnt_d   = scnt_q + {{(CNT_W-1){1'b0}}, st_ok};
      if (tv_d) tohost_d = ddt_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tohost_q <= '0;
         tv_q     <= 1'b0;
         emis_q   <= 1'b0;
         erng_q   <= 1'b0;
         lcnt_q   <= '0;
         scnt_q   <= '0;
      end else begin
         tohost_q <= tohost_d;
         tv_q     <= tv_d;
         emis_q   <= emis_d;
         erng_q   <= erng_d;
         lcnt_q   <= lcnt_d;
         scnt_q   <= scnt_d;
      end
   end

   // RAM is never cleared; a store coinciding with reset is simply dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (!rst && ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= st_lanes[8*i +: 8];
         end
      end
   end

   assign tohost         = tohost_q;
   assign tohost_valid   = tv_q;
   assign err_misaligned = emis_q;
   assign err_range      = erng_q;
   assign load_cnt       = lcnt_q;
   assign store_cnt      = scnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a byte-array model.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam int          CW    = 8;     // narrow counters keep the wrap test short
   localparam int          DEPTH = DEF_DEPTH_WORDS;
   localparam logic [31:0] BASE  = DEF_BASE_ADDR;
   localparam logic [31:0] TH    = DEF_TOHOST_ADDR;

   logic          clk = 1'b0, rst = 1'b1;
   logic          mreq = 1'b0, write = 1'b0;
   logic [1:0]    byte_size = 2'b00;
   logic [31:0]   dad = '0, ddt_in = '0;
   logic [31:0]   ddt_out, tohost;
   logic          tohost_valid, err_misaligned, err_range;
   logic [CW-1:0] load_cnt, store_cnt;

   dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .TOHOST_ADDR(TH), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .mreq(mreq), .write(write), .byte_size(byte_size),
      .dad(dad), .ddt_in(ddt_in), .ddt_out(ddt_out), .tohost(tohost),
      .tohost_valid(tohost_valid), .err_misaligned(err_misaligned), .err_range(err_range),
      .load_cnt(load_cnt), .store_cnt(store_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   // reference state
   logic [7:0]    m_ram [0:4*DEPTH-1];
   logic [31:0]   m_tohost = '0;
   logic          m_tv = 0, m_mis = 0, m_rng = 0;
   logic [CW-1:0] m_lc = '0, m_sc = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_state();
      chk("tohost", tohost, m_tohost);
      chk("tohost_valid", 32'(tohost_valid), 32'(m_tv));
      chk("err_misaligned", 32'(err_misaligned), 32'(m_mis));
      chk("err_range", 32'(err_range), 32'(m_rng));
      chk("load_cnt", 32'(load_cnt), 32'(m_lc));
      chk("store_cnt", 32'(store_cnt), 32'(m_sc));
   endtask

   // One bus cycle: drive at negedge, check the load data, model the edge, check state.
   task automatic step(input bit rq, input bit wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d, output logic [31:0] obs);
      int n;
      bit in_ram, is_th, mis, rng, good;
      logic [31:0] exp, off;
      @(negedge clk);
      mreq = rq; write = wr; byte_size = sz; dad = a; ddt_in = d;
      n      = (sz == SZ_WORD) ? 4 : (sz == SZ_HALF) ? 2 : (sz == SZ_BYTE) ? 1 : 0;
      off    = a - BASE;
      in_ram = (a >= BASE) && (a < BASE + 4 * DEPTH);
      is_th  = (a == TH) && (n == 4);
      mis    = (n == 0) ? 1'b1 : ((a % n) != 0);
      rng    = !in_ram && !is_th;
      good   = rq && !mis && !rng;
      exp    = '0;
      if (good && !wr) begin
         if (is_th) exp = m_tohost;
         else for (int i = 0; i < n; i++) exp[8*i +: 8] = m_ram[int'(off) + i];
      end
      #1;
      obs = ddt_out;
      chk("ddt_out", ddt_out, exp);
      @(posedge clk);
      if (rq) begin
         m_mis = m_mis | mis;
         m_rng = m_rng | rng;
      end
      m_tv = good && wr && is_th;
      if (good && wr) begin
         m_sc = m_sc + 1'b1;
         if (is_th) m_tohost = d;
         else for (int i = 0; i < n; i++) m_ram[int'(off) + i] = d[8*i +: 8];
      end
      if (good && !wr) m_lc = m_lc + 1'b1;
      #1;
      chk_state();
   endtask

   logic [31:0] o, word0_old;
   int r, w;

   initial begin
      // reset state
      #12;
      chk_state();
      @(negedge clk);
      rst = 1'b0;

      // directed
      step(1, 1, SZ_WORD, 32'h0002_0000, 32'hDEAD_BEEF, o);
      step(1, 0, SZ_WORD, 32'h0002_0000, 32'h0, o);
      chk("tp_word_load", o, 32'hDEAD_BEEF);
      chk("tp_store_cnt1", 32'(store_cnt), 32'd1);
      chk("tp_load_cnt1", 32'(load_cnt), 32'd1);
      step(1, 1, SZ_BYTE, 32'h0002_0002, 32'h0000_005A, o);
      step(1, 0, SZ_WORD, 32'h0002_0000, 32'h0, o);
      chk("tp_byte_merge", o, 32'hDE5A_BEEF);
      step(1, 0, SZ_BYTE, 32'h0002_0003, 32'h0, o);
      chk("tp_byte_load", o, 32'h0000_00DE);
      step(1, 1, SZ_HALF, 32'h0002_0001, 32'h0000_1234, o);
      chk("tp_mis_flag", 32'(err_misaligned), 32'd1);
      chk("tp_mis_scnt", 32'(store_cnt), 32'd2);
      step(1, 0, SZ_WORD, 32'h0002_0000, 32'h0, o);
      chk("tp_mis_nowrite", o, 32'hDE5A_BEEF);
      for (int i = 0; i < 10; i++) step(0, 1, SZ_RSVD, 32'h0002_0001, 32'hFFFF_FFFF, o);
      chk("tp_mis_sticky", 32'(err_misaligned), 32'd1);
      step(1, 0, SZ_WORD, 32'h0001_0000, 32'h0, o);
      chk("tp_rng_data", o, 32'h0);
      chk("tp_rng_flag", 32'(err_range), 32'd1);
      chk("tp_rng_lcnt", 32'(load_cnt), 32'd4);
      step(1, 1, SZ_WORD, TH, 32'h0000_0001, o);
      chk("tp_tohost", tohost, 32'h1);
      chk("tp_tv_hi", 32'(tohost_valid), 32'd1);
      chk("tp_th_scnt", 32'(store_cnt), 32'd3);
      step(0, 0, SZ_WORD, 32'h0, 32'h0, o);
      chk("tp_tv_lo", 32'(tohost_valid), 32'd0);

      // prefill the random window: words 0..15 and the top four words
      for (int k = 0; k < 20; k++) begin
         w = (k < 16) ? k : DEPTH - 20 + k;
         step(1, 1, SZ_WORD, BASE + 32'(4 * w), $urandom, o);
      end

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            step(0, 1'($urandom), 2'($urandom_range(0, 3)), BASE + 32'($urandom_range(0, 63)), $urandom, o);
         end else if (r == 1) begin
            if ($urandom_range(0, 1) == 1)
               step(1, 1'($urandom), 2'($urandom_range(0, 3)), BASE - 32'($urandom_range(1, 256)), $urandom, o);
            else
               step(1, 1'($urandom), 2'($urandom_range(0, 3)), BASE + 32'(4 * DEPTH + $urandom_range(0, 1000)), $urandom, o);
         end else if (r == 2) begin
            step(1, 1'($urandom), SZ_WORD, TH, $urandom, o);
         end else begin
            w = $urandom_range(0, 19);
            w = (w < 16) ? w : DEPTH - 20 + w;
            step(1, 1'($urandom), 2'($urandom_range(0, 3)), BASE + 32'(4 * w + $urandom_range(0, 3)), $urandom, o);
         end
      end

      // drive both counters to all-ones, check wrap, then back to all-ones
      while (m_lc != '1) step(1, 0, SZ_WORD, BASE, 32'h0, o);
      chk("lcnt_ones", 32'(load_cnt), 32'hFF);
      step(1, 0, SZ_HALF, BASE + 32'd2, 32'h0, o);
      chk("lcnt_wrap", 32'(load_cnt), 32'h0);
      while (m_lc != '1) step(1, 0, SZ_BYTE, BASE + 32'd1, 32'h0, o);
      while (m_sc != 8'hFE) step(1, 1, SZ_WORD, BASE + 32'd20, $urandom, o);
      step(1, 1, SZ_WORD, TH, 32'hCAFE_F00D, o);
      chk("scnt_ones", 32'(store_cnt), 32'hFF);
      chk("th_before_rst", tohost, 32'hCAFE_F00D);
      word0_old = {m_ram[3], m_ram[2], m_ram[1], m_ram[0]};

      // async reset in the middle of a store cycle
      @(negedge clk);
      mreq = 1'b1; write = 1'b1; byte_size = SZ_WORD; dad = BASE; ddt_in = 32'h0BAD_0BAD;
      #2 rst = 1'b1;
      #1;
      m_tohost = '0; m_tv = 0; m_mis = 0; m_rng = 0; m_lc = '0; m_sc = '0;
      chk_state();
      @(posedge clk);
      #1 chk_state();
      @(negedge clk);
      rst = 1'b0; mreq = 1'b0;
      step(1, 0, SZ_WORD, BASE, 32'h0, o);
      chk("ram_kept", o, word0_old);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
